scan_index_sequencer: RTL and testbench

//  Upstream stage of the 3-to-8 line decoder: generates the 3-bit select (x,y,z; x = MSB) that
//  the decoder turns into one-hot lines, e.g. for LED/row scanning. The index advances once per

---
 rtl/scan_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/scan_index_sequencer.sv | 107 ++++++++++
 tb/tb_scan_index_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared encodings and constants for the scan index sequencer
package scan_pkg;

  // Stepping mode applied on each prescaled tick
  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Ping-pong travel direction; this is the FSM state
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int             IDX_W   = 3;
  localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the clock into one enabled tick every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is combinational so the index register can update on the same edge
  assign tick = en && (cnt_q == CNT_LAST);

  // Next count: clear wins, hold while disabled, wrap to zero on the tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_index_sequencer.sv
// rtl/scan_index_sequencer.sv - 3-bit scan index generator for a 3-to-8 line decoder
module scan_index_sequencer
  import scan_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       step,
  output logic       wrap
);

  logic             tick;
  logic [IDX_W-1:0] idx_q, idx_d;
  dir_e             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // Next index, direction and pulses; load overrides and drops any coincident tick
  always_comb begin
    idx_d  = idx_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = load_val;
      dir_d = DIR_UP;
    end else if (tick) begin
      case (mode_e'(mode))
        MODE_UP: begin
          idx_d  = idx_q + 3'd1;
          step_d = 1'b1;
          wrap_d = (idx_q == IDX_MAX);
        end
        MODE_DOWN: begin
          idx_d  = idx_q - 3'd1;
          step_d = 1'b1;
          wrap_d = (idx_q == '0);
        end
        MODE_PING: begin
          step_d = 1'b1;
          if (dir_q == DIR_UP) begin
            if (idx_q == IDX_MAX) begin
              idx_d  = IDX_MAX - 3'd1;
              dir_d  = DIR_DOWN;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            if (idx_q == '0) begin
              idx_d  = 3'd1;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q - 3'd1;
            end
          end
        end
        default: begin
          idx_d = idx_q;
        end
      endcase
    end
  end

  // State and pulse registers, all updated on the same tick edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign x    = idx_q[2];
  assign y    = idx_q[1];
  assign z    = idx_q[0];
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// tb/tb_scan_index_sequencer.sv - directed self-checking bench for scan_index_sequencer
module tb_scan_index_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: TICK_DIV=4
  logic       a_rst_n, a_en, a_load;
  logic [1:0] a_mode;
  logic [2:0] a_load_val;
  logic       a_x, a_y, a_z, a_step, a_wrap;

  // Instance B: TICK_DIV=1
  logic       b_rst_n, b_en, b_load;
  logic [1:0] b_mode;
  logic [2:0] b_load_val;
  logic       b_x, b_y, b_z, b_step, b_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  scan_index_sequencer #(.TICK_DIV(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .mode(a_mode), .load(a_load),
    .load_val(a_load_val), .x(a_x), .y(a_y), .z(a_z), .step(a_step), .wrap(a_wrap)
  );

  scan_index_sequencer #(.TICK_DIV(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode), .load(b_load),
    .load_val(b_load_val), .x(b_x), .y(b_y), .z(b_z), .step(b_step), .wrap(b_wrap)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_a();
    return int'({a_x, a_y, a_z});
  endfunction

  function automatic int idx_b();
    return int'({b_x, b_y, b_z});
  endfunction

  // Run n non-tick cycles on instance A checking that the index and pulses stay quiet
  task automatic quiet_a(input int n, input int exp_idx, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc();
      check({tag, "_idx"}, idx_a(), exp_idx);
      check({tag, "_step"}, int'(a_step), 0);
      check({tag, "_wrap"}, int'(a_wrap), 0);
    end
  endtask

  // Ping-pong expected sequence with TICK_DIV=1 starting from 0
  int pp_idx  [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int pp_wrap [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    a_rst_n = 1'b0; a_en = 1'b1; a_mode = 2'b00; a_load = 1'b0; a_load_val = 3'd0;
    b_rst_n = 1'b0; b_en = 1'b1; b_mode = 2'b10; b_load = 1'b0; b_load_val = 3'd0;
    cyc();
    cyc();
    check("rst_idx", idx_a(), 0);
    check("rst_step", int'(a_step), 0);
    check("rst_wrap", int'(a_wrap), 0);

    // 1: up count, first step after 4 edges, wrap at 7->0
    a_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      quiet_a(3, (k - 1) % 8, "up_wait");
      cyc();
      check("up_idx", idx_a(), k % 8);
      check("up_step", int'(a_step), 1);
      check("up_wrap", int'(a_wrap), (k == 8) ? 1 : 0);
    end

    // 2: down from 0 wraps to 7, then 6,5,4
    a_mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      quiet_a(3, (k == 0) ? 0 : 8 - k, "dn_wait");
      cyc();
      check("dn_idx", idx_a(), 7 - k);
      check("dn_step", int'(a_step), 1);
      check("dn_wrap", int'(a_wrap), (k == 0) ? 1 : 0);
    end

    // 4: load on the tick cycle drops the tick and restarts the prescaler
    a_mode = 2'b00;
    quiet_a(3, 4, "ld_pre");
    a_load = 1'b1; a_load_val = 3'd5;
    cyc();
    a_load = 1'b0;
    check("ld_idx", idx_a(), 5);
    check("ld_step", int'(a_step), 0);
    check("ld_wrap", int'(a_wrap), 0);
    quiet_a(3, 5, "ld_post");
    cyc();
    check("ld_next_idx", idx_a(), 6);
    check("ld_next_step", int'(a_step), 1);

    // 5: freeze at cnt=2 for 10 cycles, tick two cycles after resume
    quiet_a(2, 6, "en_pre");
    a_en = 1'b0;
    quiet_a(10, 6, "en_off");
    a_en = 1'b1;
    quiet_a(1, 6, "en_res");
    cyc();
    check("en_idx", idx_a(), 7);
    check("en_step", int'(a_step), 1);

    // 6: ping-pong turn at 7 to DOWN, then reset mid-cycle
    a_mode = 2'b10;
    quiet_a(3, 7, "pp_wait");
    cyc();
    check("ppa_idx", idx_a(), 6);
    check("ppa_wrap", int'(a_wrap), 1);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("mrst_idx", idx_a(), 0);
    check("mrst_step", int'(a_step), 0);
    check("mrst_wrap", int'(a_wrap), 0);
    cyc();
    a_rst_n = 1'b1;
    quiet_a(3, 0, "mrst_wait");
    cyc();
    check("mrst_dir_idx", idx_a(), 1);
    check("mrst_dir_step", int'(a_step), 1);
    check("mrst_dir_wrap", int'(a_wrap), 0);

    // 3: ping-pong with a tick every cycle on instance B
    b_rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      check("pp_idx", idx_b(), pp_idx[k]);
      check("pp_step", int'(b_step), 1);
      check("pp_wrap", int'(b_wrap), pp_wrap[k]);
    end

    // hold: index frozen, no pulses while the prescaler keeps running
    b_mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("hold_idx", idx_b(), 2);
      check("hold_step", int'(b_step), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
